// File: rtl/parity_frame_tx.sv
// Serializing parity-frame transmitter: start bit, DATA_W data bits LSB first,
// even/odd parity bit and stop bit on a single idle-high line.
module parity_frame_tx #(
  parameter int unsigned DATA_W       = 9,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_odd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state, state_d;
  logic [TICK_W-1:0]   tick, tick_d;
  logic [BIT_W-1:0]    bitc, bitc_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic                par, par_d;
  logic                tx_d, ready_d, busy_d, done_d;
  logic                accept_c, period_end_c;

  assign accept_c     = in_valid & in_ready;
  assign period_end_c = (tick == TICK_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick     <= '0;
      bitc     <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_out   <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      tick     <= tick_d;
      bitc     <= bitc_d;
      shreg    <= shreg_d;
      par      <= par_d;
      tx_out   <= tx_d;
      in_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state logic: each state lasts one bit period, DATA lasts DATA_W of them
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (accept_c)                            state_d = S_START;
      S_START:  if (period_end_c)                        state_d = S_DATA;
      S_DATA:   if (period_end_c && (bitc == BIT_LAST))  state_d = S_PARITY;
      S_PARITY: if (period_end_c)                        state_d = S_STOP;
      S_STOP:   if (period_end_c)                        state_d = S_IDLE;
      default:                                           state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values, derived from the upcoming state
  always_comb begin
    tick_d  = '0;
    bitc_d  = bitc;
    shreg_d = shreg;
    par_d   = par;
    tx_d    = 1'b1;

    if (state_d != state) begin
      bitc_d = '0;
    end else if (state != S_IDLE) begin
      tick_d = period_end_c ? '0 : tick + TICK_W'(1);
      if ((state == S_DATA) && period_end_c) begin
        bitc_d = bitc + BIT_W'(1);
      end
    end

    if ((state == S_DATA) && period_end_c) begin
      shreg_d = shreg >> 1;
    end

    if (accept_c) begin
      shreg_d = in_data;
      par_d   = in_odd ? ~^in_data : ^in_data;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state == S_STOP) && period_end_c;
  end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serializing parity-frame transmitter: the generating end for the team's 9-input parity-check cone. It accepts a DATA_W-bit word over a valid/ready handshake. It computes an even or odd parity bit and shifts out a framed serial stream on one wire: start bit, data LSB first, parity bit, stop bit. It sits upstream of the parity-check logic and drives its data inputs in test harnesses.

## Interface
- DATA_W, 9: payload width; legal range 1..32.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1..65535.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; overrides every other input.
- in_data  input  DATA_W  payload word; sampled on accept.
- in_odd  input  1  parity mode; sampled on accept. 0 = even (data+parity has even ones), 1 = odd.
- in_valid  input  1  payload offered.
- in_ready  output  1  block can accept; registered.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.

## Operation
- Reset values: in_ready=1, tx_out=1, busy=0, done=0, state=IDLE, bit and tick counters=0.
- Accept occurs on a rising edge where in_valid=1, in_ready=1 and rst=0. On accept:
  - Latch in_data into the shift register.
  - Latch parity: ^in_data for even mode, ~^in_data for odd mode.
  - in_ready->0, busy->1, state->START.
- State machine. Each state holds for CLKS_PER_BIT cycles, counted by the tick counter.
  - IDLE: tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0]. Shift right at the end of each bit period. Leave after DATA_W bit periods.
  - PARITY: tx_out=latched parity bit.
  - STOP: tx_out=1. At the end of the period: state->IDLE, in_ready->1, busy->0, done->1 for exactly one cycle.
- Input stability: in_data and in_odd are ignored outside the accept edge. Changes mid-frame have no effect.
- in_valid held high continuously: the next word is accepted on the first cycle in_ready=1, i.e. the cycle done=1. This is back-to-back with zero idle bit periods.
- Reset mid-frame: on the next edge all outputs return to reset values. The partial frame is abandoned with no done pulse and the line goes to 1 immediately.
- Counter widths:
  - tick counter: $clog2(CLKS_PER_BIT) bits, minimum 1.
  - bit counter: $clog2(DATA_W) bits, minimum 1.
  - Both counters clear on every state change. No wrap within a state.
- CLKS_PER_BIT=1: each bit lasts one cycle; the FSM must not skip or repeat any bit.

## Timing
- Accept edge at cycle T (registered). tx_out falls to 0 in cycle T+1, i.e. start bit occupies cycles T+1..T+CLKS_PER_BIT.
- Data bit k occupies cycles T+1+(k+1)*CLKS_PER_BIT .. T+(k+2)*CLKS_PER_BIT.
- Parity occupies the (DATA_W+2)th bit period; stop occupies the (DATA_W+3)th.
- Frame length is F=(DATA_W+3)*CLKS_PER_BIT cycles. Default F=48.
- done=1, in_ready=1 and busy=0 in cycle T+F+1.
- Sustained throughput with continuous valid: one word per F+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset and idle: hold rst 3 cycles, then in_valid=0 for 10 cycles -> tx_out=1, in_ready=1, busy=0, done=0 throughout.
- Even frame, defaults: in_data=9'h1A5, in_odd=0, one-cycle valid. Required response:
  - tx_out per 4-cycle period: 0 | 1,0,1,0,0,1,0,1,1 | parity 1 | stop 1.
  - done pulses exactly once, 49 cycles after accept.
- Odd mode: in_data=9'h000, in_odd=1 -> start 0, nine 0s, parity 1, stop 1. Repeat with in_odd=0 -> parity 0.
- Back-to-back: in_valid held high with 9'h1A5 then 9'h0FF (even). Required response:
  - Second accept on the same cycle as the first done.
  - No idle bit between frames.
  - Second parity bit = 0 (8 ones).
- Reset mid-frame: assert rst during data bit 4 of 9'h1A5 -> next cycle tx_out=1, in_ready=1, busy=0, and no done pulse. A new word of 9'h001 then transmits cleanly with parity 1.
- CLKS_PER_BIT=1, DATA_W=1: in_data=1, even -> tx_out over 4 cycles = 0,1,1,1, and done on the 5th cycle.
